// File: rtl/vga_pkg.sv
// vga_pkg
// Shared 640x480@60 timing constants for the raster generator and anything
// that needs to reason about screen geometry (colour mapper, frame reader).
// Contents: per-axis visible/porch/sync widths, line and frame totals,
// sync pulse bounds, and the coordinate type used on DrawX/DrawY.
package vga_pkg;

   localparam int H_VISIBLE = 640;
   localparam int H_FRONT   = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BACK    = 48;
   localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

   localparam int V_VISIBLE = 480;
   localparam int V_FRONT   = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BACK    = 33;
   localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   // Sync pulses cover [START, END) on their axis.
   localparam int HS_START  = H_VISIBLE + H_FRONT;
   localparam int HS_END    = HS_START + H_SYNC;
   localparam int VS_START  = V_VISIBLE + V_FRONT;
   localparam int VS_END    = VS_START + V_SYNC;

   localparam int COORD_W   = 10;
   typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/wrap_counter.sv
// wrap_counter
// Modulo-N up counter used for both raster axes.
// Ports:
//   Clk   - system clock
//   Reset - synchronous, active-high; clears count
//   en    - advance enable
//   count - current value, 0..N-1
//   wrap  - combinational, high when the next enabled edge returns count to 0
module wrap_counter
   import vga_pkg::*;
#(
   parameter int N = H_TOTAL,
   parameter int W = COORD_W
)
(
   input  logic         Clk,
   input  logic         Reset,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         wrap
);

   assign wrap = en && (count == W'(N - 1));

   // Advance on enable, folding back to zero at the top of the range.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         count <= '0;
      end else if (en) begin
         count <= wrap ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Raster scan generator driven from the system clock with a pixel enable.
// Ports:
//   Clk, Reset   - system clock, synchronous active-high reset
//   pixel_ce     - one-Clk strobe; counters advance on this cycle's edge
//   VGA_CLK      - registered 50% duty pixel clock for the DAC
//   VGA_HS/VS    - active-low syncs, aligned with DrawX/DrawY
//   VGA_BLANK_N  - high inside the visible area
//   VGA_SYNC_N   - tied low
//   DrawX/DrawY  - current pixel coordinates
//   line_start   - one-Clk pulse in the cycle DrawX shows 0
//   frame_start  - one-Clk pulse in the cycle (DrawX, DrawY) shows (0, 0)
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int CLK_DIV   = 2,
   parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
   parameter int H_FRONT   = vga_pkg::H_FRONT,
   parameter int H_SYNC    = vga_pkg::H_SYNC,
   parameter int H_BACK    = vga_pkg::H_BACK,
   parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
   parameter int V_FRONT   = vga_pkg::V_FRONT,
   parameter int V_SYNC    = vga_pkg::V_SYNC,
   parameter int V_BACK    = vga_pkg::V_BACK
)
(
   input  logic       Clk,
   input  logic       Reset,
   output logic       pixel_ce,
   output logic       VGA_CLK,
   output logic       VGA_HS,
   output logic       VGA_VS,
   output logic       VGA_BLANK_N,
   output logic       VGA_SYNC_N,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       line_start,
   output logic       frame_start
);

   localparam int DIV_W       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int LINE_LEN    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int FRAME_LINES = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam coord_t HSYNC_LO = coord_t'(H_VISIBLE + H_FRONT);
   localparam coord_t HSYNC_HI = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam coord_t VSYNC_LO = coord_t'(V_VISIBLE + V_FRONT);
   localparam coord_t VSYNC_HI = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam coord_t H_VIS_C  = coord_t'(H_VISIBLE);
   localparam coord_t V_VIS_C  = coord_t'(V_VISIBLE);

   logic [DIV_W-1:0] div;
   logic [DIV_W-1:0] div_next;
   logic             div_last;
   logic             h_wrap;
   logic             v_wrap;
   coord_t           x_next;
   coord_t           y_next;

   assign div_last   = (div == DIV_W'(CLK_DIV - 1));
   assign div_next   = div_last ? '0 : div + 1'b1;
   assign pixel_ce   = div_last && !Reset;
   assign VGA_SYNC_N = 1'b0;

   // Divider and DAC clock. VGA_CLK looks at the divider value being loaded
   // so it is high for exactly the upper half of every pixel period.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         div     <= '0;
         VGA_CLK <= 1'b0;
      end else begin
         div     <= div_next;
         VGA_CLK <= (div_next >= DIV_W'(CLK_DIV / 2));
      end
   end

   wrap_counter #(.N(LINE_LEN), .W(COORD_W)) u_hcount (
      .Clk   (Clk),
      .Reset (Reset),
      .en    (pixel_ce),
      .count (DrawX),
      .wrap  (h_wrap)
   );

   wrap_counter #(.N(FRAME_LINES), .W(COORD_W)) u_vcount (
      .Clk   (Clk),
      .Reset (Reset),
      .en    (h_wrap),
      .count (DrawY),
      .wrap  (v_wrap)
   );

   // Coordinates the counters will hold after this cycle's pixel edge.
   always_comb begin
      x_next = h_wrap ? '0 : DrawX + 1'b1;
      y_next = DrawY;
      if (v_wrap) begin
         y_next = '0;
      end else if (h_wrap) begin
         y_next = DrawY + 1'b1;
      end
   end

   // Syncs and blank are decoded from the upcoming coordinates and loaded on
   // the same edge as the counters, so they never lag DrawX/DrawY. Loading
   // only on pixel edges also keeps blank low until the first pixel edge.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         VGA_HS      <= 1'b1;
         VGA_VS      <= 1'b1;
         VGA_BLANK_N <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         line_start  <= h_wrap;
         frame_start <= v_wrap;
         if (pixel_ce) begin
            VGA_HS      <= !((x_next >= HSYNC_LO) && (x_next < HSYNC_HI));
            VGA_VS      <= !((y_next >= VSYNC_LO) && (y_next < VSYNC_HI));
            VGA_BLANK_N <= (x_next < H_VIS_C) && (y_next < V_VIS_C);
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Three instances share one clock: A uses the full 640x480 geometry for the
// line-level checks, B and C use a tiny 15x11 raster (CLK_DIV 2 and 4) so
// that vertical sync, frame wrap and frame period can be reached quickly.
// Every cycle each instance is compared against a model that derives the
// expected raster position directly from the cycle count since reset.
module tb_vga_timing_gen;

   typedef struct {
      int d;
      int hv, hf, hs, hb;
      int vv, vf, vs, vb;
   } geo_t;

   typedef struct {
      logic ce, vclk, hs, vs, blank, ls, fs;
      int   x, y;
   } exp_t;

   logic       clk;
   logic       rstA, rstB, rstC;
   logic       ceA, vclkA, hsA, vsA, blankA, syncA, lsA, fsA;
   logic       ceB, vclkB, hsB, vsB, blankB, syncB, lsB, fsB;
   logic       ceC, vclkC, hsC, vsC, blankC, syncC, lsC, fsC;
   logic [9:0] xA, yA, xB, yB, xC, yC;

   geo_t gA, gB, gC;
   int   kA, kB, kC;
   int   cyc;
   bit   primed;
   int   lastFsB, lastFsC;
   int   nAssert, nFail;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   vga_timing_gen dutA (
      .Clk(clk), .Reset(rstA), .pixel_ce(ceA), .VGA_CLK(vclkA), .VGA_HS(hsA),
      .VGA_VS(vsA), .VGA_BLANK_N(blankA), .VGA_SYNC_N(syncA), .DrawX(xA),
      .DrawY(yA), .line_start(lsA), .frame_start(fsA)
   );

   vga_timing_gen #(
      .CLK_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
   ) dutB (
      .Clk(clk), .Reset(rstB), .pixel_ce(ceB), .VGA_CLK(vclkB), .VGA_HS(hsB),
      .VGA_VS(vsB), .VGA_BLANK_N(blankB), .VGA_SYNC_N(syncB), .DrawX(xB),
      .DrawY(yB), .line_start(lsB), .frame_start(fsB)
   );

   vga_timing_gen #(
      .CLK_DIV(4), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
   ) dutC (
      .Clk(clk), .Reset(rstC), .pixel_ce(ceC), .VGA_CLK(vclkC), .VGA_HS(hsC),
      .VGA_VS(vsC), .VGA_BLANK_N(blankC), .VGA_SYNC_N(syncC), .DrawX(xC),
      .DrawY(yC), .line_start(lsC), .frame_start(fsC)
   );

   // Reference: k is the 1-based cycle index since the last reset edge.
   // n pixel edges have completed before cycle k; position follows from n.
   function automatic exp_t expectedOut(input geo_t g, input int k, input bit rstNow);
      exp_t e;
      int   n, ht, vt, x, y;
      ht = g.hv + g.hf + g.hs + g.hb;
      vt = g.vv + g.vf + g.vs + g.vb;
      n  = (k - 1) / g.d;
      x  = n % ht;
      y  = (n / ht) % vt;
      e.x     = x;
      e.y     = y;
      e.ce    = !rstNow && ((k % g.d) == 0);
      e.vclk  = ((k - 1) % g.d) >= (g.d / 2);
      e.hs    = !((x >= g.hv + g.hf) && (x < g.hv + g.hf + g.hs));
      e.vs    = !((y >= g.vv + g.vf) && (y < g.vv + g.vf + g.vs));
      e.blank = (n > 0) && (x < g.hv) && (y < g.vv);
      e.ls    = (n >= 1) && (((k - 1) % g.d) == 0) && (x == 0);
      e.fs    = e.ls && (y == 0);
      return e;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      nAssert++;
      assert (observed === expected)
      else begin
         nFail++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic checkDut(input string nm, input geo_t g, input int k, input bit rstNow,
                           input logic ce, input logic vclk, input logic hs,
                           input logic vs, input logic blank, input logic syncn,
                           input logic ls, input logic fs,
                           input logic [9:0] x, input logic [9:0] y);
      exp_t e;
      if (k == 0) return;
      e = expectedOut(g, k, rstNow);
      checkOutput({nm, ".pixel_ce"},    {31'b0, ce},    {31'b0, e.ce});
      checkOutput({nm, ".VGA_CLK"},     {31'b0, vclk},  {31'b0, e.vclk});
      checkOutput({nm, ".VGA_HS"},      {31'b0, hs},    {31'b0, e.hs});
      checkOutput({nm, ".VGA_VS"},      {31'b0, vs},    {31'b0, e.vs});
      checkOutput({nm, ".VGA_BLANK_N"}, {31'b0, blank}, {31'b0, e.blank});
      checkOutput({nm, ".VGA_SYNC_N"},  {31'b0, syncn}, 32'd0);
      checkOutput({nm, ".line_start"},  {31'b0, ls},    {31'b0, e.ls});
      checkOutput({nm, ".frame_start"}, {31'b0, fs},    {31'b0, e.fs});
      checkOutput({nm, ".DrawX"},       {22'b0, x},     32'(e.x));
      checkOutput({nm, ".DrawY"},       {22'b0, y},     32'(e.y));
   endtask

   // One Clk cycle: account for the edge just passed, drive this cycle's
   // resets, then compare all instances and track frame periods.
   task automatic applyStimulus(input bit ra, input bit rb, input bit rc);
      @(negedge clk);
      if (primed) begin
         kA = rstA ? 1 : ((kA == 0) ? 0 : kA + 1);
         kB = rstB ? 1 : ((kB == 0) ? 0 : kB + 1);
         kC = rstC ? 1 : ((kC == 0) ? 0 : kC + 1);
         cyc++;
      end
      primed = 1'b1;
      rstA = ra;
      rstB = rb;
      rstC = rc;
      #1;
      checkDut("A", gA, kA, ra, ceA, vclkA, hsA, vsA, blankA, syncA, lsA, fsA, xA, yA);
      checkDut("B", gB, kB, rb, ceB, vclkB, hsB, vsB, blankB, syncB, lsB, fsB, xB, yB);
      checkDut("C", gC, kC, rc, ceC, vclkC, hsC, vsC, blankC, syncC, lsC, fsC, xC, yC);
      if (kB != 0 && fsB === 1'b1) begin
         if (lastFsB >= 0) checkOutput("B.frame_period", 32'(cyc - lastFsB), 32'd330);
         lastFsB = cyc;
      end
      if (kC != 0 && fsC === 1'b1) begin
         if (lastFsC >= 0) checkOutput("C.frame_period", 32'(cyc - lastFsC), 32'd660);
         lastFsC = cyc;
      end
      if (rb) lastFsB = -1;
      if (rc) lastFsC = -1;
   endtask

   initial begin
      int  hsFall, hsRise, blankFall, lsCount, lsY;
      int  vsFall, vsRise, fsCount, badBlank;
      bit  prevHs, prevBlank, prevVs, found;

      nAssert = 0;
      nFail   = 0;
      cyc     = 0;
      primed  = 1'b0;
      kA = 0; kB = 0; kC = 0;
      lastFsB = -1;
      lastFsC = -1;
      rstA = 1'b1; rstB = 1'b1; rstC = 1'b1;
      gA.d = 2; gA.hv = 640; gA.hf = 16; gA.hs = 96; gA.hb = 48;
      gA.vv = 480; gA.vf = 10; gA.vs = 2; gA.vb = 33;
      gB.d = 2; gB.hv = 8; gB.hf = 2; gB.hs = 3; gB.hb = 2;
      gB.vv = 6; gB.vf = 1; gB.vs = 2; gB.vb = 2;
      gC = gB;
      gC.d = 4;

      // Reset held for three cycles; values against fixed constants.
      repeat (3) applyStimulus(1, 1, 1);
      checkOutput("rst.DrawX",       {22'b0, xA},     32'd0);
      checkOutput("rst.DrawY",       {22'b0, yA},     32'd0);
      checkOutput("rst.VGA_HS",      {31'b0, hsA},    32'd1);
      checkOutput("rst.VGA_VS",      {31'b0, vsA},    32'd1);
      checkOutput("rst.VGA_BLANK_N", {31'b0, blankA}, 32'd0);
      checkOutput("rst.VGA_CLK",     {31'b0, vclkA},  32'd0);

      // First pixel edge lands in cycle 2 after release.
      applyStimulus(0, 0, 0);
      checkOutput("cyc1.pixel_ce",    {31'b0, ceA},    32'd0);
      checkOutput("cyc1.VGA_BLANK_N", {31'b0, blankA}, 32'd0);
      applyStimulus(0, 0, 0);
      checkOutput("cyc2.pixel_ce",    {31'b0, ceA},    32'd1);
      checkOutput("cyc2.DrawX",       {22'b0, xA},     32'd0);
      applyStimulus(0, 0, 0);
      checkOutput("cyc3.DrawX",       {22'b0, xA},     32'd1);
      checkOutput("cyc3.VGA_BLANK_N", {31'b0, blankA}, 32'd1);

      // One full 800-pixel line on the default geometry.
      hsFall = -1; hsRise = -1; blankFall = -1; lsCount = 0; lsY = -1;
      prevHs = 1'b1; prevBlank = 1'b1;
      for (int i = 0; i < 1700; i++) begin
         applyStimulus(0, 0, 0);
         if (prevHs && !hsA && hsFall < 0) hsFall = int'(xA);
         if (!prevHs && hsA && hsRise < 0) hsRise = int'(xA);
         if (prevBlank && !blankA && blankFall < 0) blankFall = int'(xA);
         if (lsA) begin
            lsCount++;
            lsY = int'(yA);
         end
         prevHs    = hsA;
         prevBlank = blankA;
      end
      checkOutput("line.hs_fall_x",    32'(hsFall),    32'd656);
      checkOutput("line.hs_rise_x",    32'(hsRise),    32'd752);
      checkOutput("line.blank_fall_x", 32'(blankFall), 32'd640);
      checkOutput("line.ls_cycles",    32'(lsCount),   32'd1);
      checkOutput("line.ls_row",       32'(lsY),       32'd1);
      checkOutput("line.DrawY",        {22'b0, yA},    32'd1);

      // Mid-frame, mid-divider reset of B at (5, 3).
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         applyStimulus(0, 0, 0);
         if (xB == 10'd5 && yB == 10'd3 && ceB == 1'b0) found = 1'b1;
      end
      checkOutput("midrst.reached", {31'b0, found}, 32'd1);
      applyStimulus(0, 1, 0);
      applyStimulus(0, 0, 0);
      checkOutput("midrst.DrawX",       {22'b0, xB},     32'd0);
      checkOutput("midrst.DrawY",       {22'b0, yB},     32'd0);
      checkOutput("midrst.line_start",  {31'b0, lsB},    32'd0);
      checkOutput("midrst.frame_start", {31'b0, fsB},    32'd0);
      checkOutput("midrst.VGA_HS",      {31'b0, hsB},    32'd1);
      checkOutput("midrst.VGA_BLANK_N", {31'b0, blankB}, 32'd0);

      // Full small frame after the reset: vertical sync and frame wrap.
      vsFall = -1; vsRise = -1; fsCount = 0; badBlank = 0; prevVs = 1'b1;
      for (int i = 0; i < 340; i++) begin
         applyStimulus(0, 0, 0);
         if (prevVs && !vsB && vsFall < 0) vsFall = int'(yB);
         if (!prevVs && vsB && vsRise < 0) vsRise = int'(yB);
         if (yB >= 10'd6 && blankB) badBlank++;
         if (fsB) fsCount++;
         prevVs = vsB;
      end
      checkOutput("frame.vs_fall_y",   32'(vsFall),   32'd7);
      checkOutput("frame.vs_rise_y",   32'(vsRise),   32'd9);
      checkOutput("frame.vblank_lit",  32'(badBlank), 32'd0);
      checkOutput("frame.fs_count",    32'(fsCount),  32'd1);

      // Free running with sporadic independent resets on every instance.
      for (int i = 0; i < 3000; i++) begin
         applyStimulus($urandom_range(0, 499) == 0,
                       $urandom_range(0, 299) == 0,
                       $urandom_range(0, 399) == 0);
      end
      repeat (700) applyStimulus(0, 0, 0);

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule
